// File: rtl/lcd_msg_scheduler.sv
// Keypad entry buffer plus LCD request arbiter (alert > full > key echo) with ready_i handshake.
// Optional build macro PIN_MASK_EN: keypad echo shows '*' instead of the digit.
module lcd_msg_scheduler #(
  parameter int MAX_DIGITS  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_detected,
  input  logic [3:0]              digito,
  input  logic                    distance,
  input  logic                    ready_i,
  output logic                    message_change,
  output logic [1:0]              sel_msg,
  output logic [7:0]              data_in,
  output logic [2:0]              buf_count,
  output logic                    full,
  output logic                    entry_valid,
  output logic [4*MAX_DIGITS-1:0] entry_code
);

  localparam int          TW      = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]  MAX_CNT = 3'(MAX_DIGITS);
  localparam logic [7:0]  BLANK   = 8'h20;

  typedef enum logic [1:0] {ESPERA, GUARDA, LLENO} entry_state_t;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_BUSY} disp_state_t;

  entry_state_t entry_state_reg, entry_state_next;
  disp_state_t  disp_reg, disp_next;

  logic [2:0]              count_reg, count_next;
  logic                    full_reg;
  logic                    valid_reg;
  logic [4*MAX_DIGITS-1:0] code_reg, code_next;
  logic [4*MAX_DIGITS-1:0] buf_packed;
  logic [7:0]              echo_reg, echo_next;
  logic                    dist_d_reg;
  logic                    req_alert_reg, req_full_reg, req_key_reg;
  logic [1:0]              sel_reg, sel_next;
  logic [7:0]              data_reg, data_next;
  logic [TW-1:0]           timer_reg, timer_next;
  logic                    seen_low_reg, seen_low_next;

  logic is_digit, is_clear, is_enter;
  logic store, empty_buf, commit, key_set, full_set;
  logic take_alert, take_full, take_key;
  logic dist_rise, dist_fall;
  logic [7:0] echo_char;

  assign is_digit  = key_detected && (digito <= 4'd9);
  assign is_clear  = key_detected && (digito == 4'hA);
  assign is_enter  = key_detected && (digito == 4'hB);
  assign dist_rise = distance && !dist_d_reg;
  assign dist_fall = !distance && dist_d_reg;

`ifdef PIN_MASK_EN
  assign echo_char = 8'h2A;
`else
  assign echo_char = {4'h3, digito};
`endif

  // One register per slot; slots beyond the write pointer stay zero so entry_code is zero-padded.
  for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_slot
    logic [3:0] slot_reg;
    always_ff @(posedge clk) begin
      if (!reset || empty_buf)
        slot_reg <= 4'h0;
      else if (store && (count_reg == 3'(gi)))
        slot_reg <= digito;
    end
    assign buf_packed[4*(MAX_DIGITS-gi)-1 -: 4] = slot_reg;
  end

  always_comb begin
    entry_state_next = entry_state_reg;
    count_next       = count_reg;
    echo_next        = echo_reg;
    store            = 1'b0;
    empty_buf        = 1'b0;
    commit           = 1'b0;
    key_set          = 1'b0;
    full_set         = 1'b0;
    if (is_clear) begin
      empty_buf        = 1'b1;
      count_next       = 3'd0;
      key_set          = 1'b1;
      echo_next        = BLANK;
      entry_state_next = ESPERA;
    end else if (is_digit && entry_state_reg != LLENO) begin
      store      = 1'b1;
      key_set    = 1'b1;
      echo_next  = echo_char;
      count_next = count_reg + 3'd1;
      if (count_reg + 3'd1 == MAX_CNT) begin
        full_set         = 1'b1;
        entry_state_next = LLENO;
      end else begin
        entry_state_next = GUARDA;
      end
    end else if (is_enter && entry_state_reg != ESPERA) begin
      commit           = 1'b1;
      empty_buf        = 1'b1;
      count_next       = 3'd0;
      echo_next        = BLANK;
      entry_state_next = ESPERA;
    end
    code_next = commit ? buf_packed : code_reg;
  end

  always_comb begin
    disp_next     = disp_reg;
    sel_next      = sel_reg;
    data_next     = data_reg;
    timer_next    = timer_reg;
    seen_low_next = seen_low_reg;
    take_alert    = 1'b0;
    take_full     = 1'b0;
    take_key      = 1'b0;
    case (disp_reg)
      D_IDLE: begin
        if (ready_i && (req_alert_reg || req_full_reg || req_key_reg)) begin
          disp_next = D_REQ;
          if (req_alert_reg) begin
            take_alert = 1'b1;
            sel_next   = 2'b11;
            data_next  = BLANK;
          end else if (req_full_reg) begin
            take_full = 1'b1;
            sel_next  = 2'b10;
            data_next = BLANK;
          end else begin
            take_key  = 1'b1;
            sel_next  = 2'b01;
            data_next = echo_reg;
          end
        end
      end
      D_REQ: begin
        disp_next     = D_BUSY;
        timer_next    = '0;
        seen_low_next = 1'b0;
      end
      D_BUSY: begin
        // Timeout only guards the missing fall; once ready_i has dropped we wait for it to return.
        if (!seen_low_reg) begin
          if (!ready_i)
            seen_low_next = 1'b1;
          else if (timer_reg == TW'(ACK_TIMEOUT - 1))
            disp_next = D_IDLE;
          else
            timer_next = timer_reg + TW'(1);
        end else if (ready_i) begin
          disp_next = D_IDLE;
        end
      end
      default: disp_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      entry_state_reg <= ESPERA;
      count_reg       <= 3'd0;
      full_reg        <= 1'b0;
      valid_reg       <= 1'b0;
      code_reg        <= '0;
      echo_reg        <= BLANK;
      dist_d_reg      <= 1'b0;
      req_alert_reg   <= 1'b0;
      req_full_reg    <= 1'b0;
      req_key_reg     <= 1'b0;
      disp_reg        <= D_IDLE;
      sel_reg         <= 2'b00;
      data_reg        <= BLANK;
      timer_reg       <= '0;
      seen_low_reg    <= 1'b0;
    end else begin
      entry_state_reg <= entry_state_next;
      count_reg       <= count_next;
      full_reg        <= (count_next == MAX_CNT);
      valid_reg       <= commit;
      code_reg        <= code_next;
      echo_reg        <= echo_next;
      dist_d_reg      <= distance;
      // A new event in the same cycle as consumption keeps the flag set.
      req_alert_reg   <= (req_alert_reg && !take_alert) || dist_rise;
      req_full_reg    <= (req_full_reg && !take_full) || full_set;
      req_key_reg     <= (req_key_reg && !take_key) || key_set || dist_fall;
      disp_reg        <= disp_next;
      sel_reg         <= sel_next;
      data_reg        <= data_next;
      timer_reg       <= timer_next;
      seen_low_reg    <= seen_low_next;
    end
  end

  assign message_change = (disp_reg == D_REQ);
  assign sel_msg        = sel_reg;
  assign data_in        = data_reg;
  assign buf_count      = count_reg;
  assign full           = full_reg;
  assign entry_valid    = valid_reg;
  assign entry_code     = code_reg;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Directed bench for lcd_msg_scheduler: logs every message_change pulse and checks against hand-derived values.
module tb_lcd_msg_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_detected = 1'b0;
  logic [3:0]  digito = 4'h0;
  logic        distance = 1'b0;
  logic        ready_i;
  logic        message_change;
  logic [1:0]  sel_msg;
  logic [7:0]  data_in;
  logic [2:0]  buf_count;
  logic        full;
  logic        entry_valid;
  logic [15:0] entry_code;

  int n_checks = 0;
  int n_errors = 0;
  bit resp_en = 1'b1;
  bit ready_hold = 1'b1;
  logic [9:0] pulse_q[$];
  time        pulse_t[$];

  lcd_msg_scheduler dut (
    .clk(clk), .reset(reset), .key_detected(key_detected), .digito(digito),
    .distance(distance), .ready_i(ready_i), .message_change(message_change),
    .sel_msg(sel_msg), .data_in(data_in), .buf_count(buf_count), .full(full),
    .entry_valid(entry_valid), .entry_code(entry_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(posedge clk);
    #1;
    key_detected = 1'b1;
    digito       = k;
    @(posedge clk);
    #1;
    key_detected = 1'b0;
  endtask

  // LCD controller model: drops ready for three cycles after each request while enabled.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        ready_i = ready_hold;
      end else if (message_change === 1'b1) begin
        ready_i = 1'b0;
        repeat (3) @(negedge clk);
        ready_i = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (message_change === 1'b1) begin
        pulse_q.push_back({sel_msg, data_in});
        pulse_t.push_back($time);
        $display("t=%0t request #%0d sel_msg=%b data_in=%h", $time, pulse_q.size() - 1, sel_msg, data_in);
      end
    end
  end

  initial begin
    // Reset with no input
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rst_pulses", 32'(pulse_q.size()), 0);
    check("rst_sel", 32'(sel_msg), 0);
    check("rst_data", 32'(data_in), 32'h20);
    check("rst_count", 32'(buf_count), 0);
    check("rst_full", 32'(full), 0);
    check("rst_valid", 32'(entry_valid), 0);

    // Key 1 with latency check, then keys 2..4
    press(4'd1);
    @(negedge clk);
    check("k1_count", 32'(buf_count), 1);
    check("k1_mc_early", 32'(message_change), 0);
    @(negedge clk);
    check("k1_mc_lat2", 32'(message_change), 1);
    check("k1_sel", 32'(sel_msg), 32'h1);
    check("k1_data", 32'(data_in), 32'h31);
    repeat (10) @(posedge clk);
    press(4'd2);
    repeat (10) @(posedge clk);
    press(4'd3);
    @(negedge clk);
    check("k3_full", 32'(full), 0);
    repeat (10) @(posedge clk);
    press(4'd4);
    @(negedge clk);
    check("k4_count", 32'(buf_count), 4);
    check("k4_full", 32'(full), 1);
    repeat (25) @(posedge clk);
    #1;
    // Full and echo raised together: full wins priority, then the last echo
    check("seq_size", 32'(pulse_q.size()), 5);
    check("seq0", 32'(pulse_q[0]), 32'h131);
    check("seq1", 32'(pulse_q[1]), 32'h132);
    check("seq2", 32'(pulse_q[2]), 32'h133);
    check("seq3_full", 32'(pulse_q[3]), 32'h220);
    check("seq4", 32'(pulse_q[4]), 32'h134);

    // Fifth digit in LLENO is ignored
    press(4'd5);
    @(negedge clk);
    check("k5_count", 32'(buf_count), 4);
    repeat (10) @(posedge clk);
    #1;
    check("k5_noreq", 32'(pulse_q.size()), 5);

    // Enter commits the entry
    press(4'hB);
    @(negedge clk);
    check("ent_valid", 32'(entry_valid), 1);
    check("ent_code", 32'(entry_code), 32'h1234);
    check("ent_count", 32'(buf_count), 0);
    check("ent_full", 32'(full), 0);
    @(negedge clk);
    check("ent_valid_1cyc", 32'(entry_valid), 0);
    repeat (10) @(posedge clk);
    #1;
    check("ent_noreq", 32'(pulse_q.size()), 5);

    // Distance rise together with a digit: alert first, then echo
    @(posedge clk);
    #1;
    key_detected = 1'b1;
    digito       = 4'd7;
    distance     = 1'b1;
    @(posedge clk);
    #1 key_detected = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("dist_size", 32'(pulse_q.size()), 7);
    check("dist_alert", 32'(pulse_q[5]), 32'h320);
    check("dist_echo", 32'(pulse_q[6]), 32'h137);
    distance = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("fall_size", 32'(pulse_q.size()), 8);
    check("fall_redraw", 32'(pulse_q[7]), 32'h137);

    // ready_i stuck high: the second request waits out the timeout
    resp_en    = 1'b0;
    ready_hold = 1'b1;
    press(4'd8);
    repeat (3) @(posedge clk);
    press(4'd9);
    @(negedge clk);
    check("to_count", 32'(buf_count), 3);
    repeat (300) @(posedge clk);
    #1;
    check("to_size", 32'(pulse_q.size()), 10);
    check("to_first", 32'(pulse_q[8]), 32'h138);
    check("to_second", 32'(pulse_q[9]), 32'h139);
    check("to_spacing", 32'(pulse_t[9] - pulse_t[8]), 32'd2570);
    repeat (300) @(posedge clk);

    // Clear redraws blank, then reset in the middle of a busy handshake
    resp_en = 1'b1;
    press(4'hA);
    repeat (15) @(posedge clk);
    #1;
    check("clr_size", 32'(pulse_q.size()), 11);
    check("clr_blank", 32'(pulse_q[10]), 32'h120);
    check("clr_count", 32'(buf_count), 0);
    press(4'd5);
    repeat (12) @(posedge clk);
    resp_en = 1'b0;
    press(4'd6);
    repeat (5) @(posedge clk);
    #1 distance = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_count", 32'(buf_count), 2);
    check("busy_size", 32'(pulse_q.size()), 13);
    check("busy_echo", 32'(pulse_q[12]), 32'h136);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    distance = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("rb_size", 32'(pulse_q.size()), 13);
    check("rb_count", 32'(buf_count), 0);
    check("rb_sel", 32'(sel_msg), 0);
    check("rb_data", 32'(data_in), 32'h20);
    check("rb_full", 32'(full), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
